bit_counter_column: RTL and testbench

Clocked, parametrised column of N stacked flip-bits wired as a Turing Tumble ripple counter, with bit 0 as the top row and LSB. A ball enters at row 0 and takes TRANSIT cycles per row. It carries downward while it meets 1-bits and leaves the column at the first 0-bit. An external gear input toggles the whole column. The block sits between ball-routing fabric (ramps, crossovers) and downstream interceptors, and replaces hand-chained single-bit cells.

---
 rtl/bit_counter_column.sv | 179 +++++++++++++++++
 tb/tb_bit_counter_column.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_counter_column.sv
// -----------------------------------------------------------------------------
// bit_counter_column
//
// A column of N stacked flip-bits wired as a ripple counter. Row 0 is the top
// row and the LSB. A ball enters at row 0, spends TRANSIT cycles on each row,
// and toggles that row's bit. It carries on downward while it meets 1-bits and
// leaves the column at the first 0-bit. A ball that carries out of row N-1
// overflows. The net effect of each ball is state = state + 1 (mod 2^N).
// An external gear pulse inverts the whole column. If the pulse arrives while
// a ball is rolling, the inversion is held back until the ball leaves.
//
// Parameters:
//   N        number of bit rows (1..16)
//   INIT     reset value of the bit column
//   TRANSIT  clock cycles a ball spends on each row (1..15)
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous, active-high reset
//   ball_in     one-cycle pulse: a ball arrives at row 0
//   gear_flip   one-cycle pulse: invert all N bits
//   ready       column empty; ball_in will be accepted
//   o_exit      one-cycle pulse: ball left the column at a 0-bit
//   o_row       row index of the last exit; holds until the next exit
//   o_overflow  one-cycle pulse: ball carried out of row N-1
//   o_jam       one-cycle pulse: ball_in dropped because the column was busy
//   state       current bit values (bit k = row k)
// -----------------------------------------------------------------------------
module bit_counter_column #(
    parameter int           N       = 4,
    parameter logic [N-1:0] INIT    = {N{1'b0}},
    parameter int           TRANSIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ball_in,
    input  logic             gear_flip,
    output logic             ready,
    output logic             o_exit,
    output logic [$clog2(N):0] o_row,
    output logic             o_overflow,
    output logic             o_jam,
    output logic [N-1:0]     state
);

    localparam int ROW_W = $clog2(N) + 1;
    localparam int T_W   = 4;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] ROLL = 1'b1;

    localparam logic [ROW_W-1:0] LAST_ROW     = ROW_W'(N - 1);
    localparam logic [T_W-1:0]   TRANSIT_LAST = T_W'(TRANSIT - 1);

    logic [0:0]       fsm_q,      fsm_d;
    logic [N-1:0]     state_q,    state_d;
    logic [ROW_W-1:0] r_q,        r_d;
    logic [T_W-1:0]   t_q,        t_d;
    logic             p_q,        p_d;
    logic             exit_q,     exit_d;
    logic             overflow_q, overflow_d;
    logic             jam_q,      jam_d;
    logic [ROW_W-1:0] row_q,      row_d;

    // Helpers for the row currently being resolved.
    logic [N-1:0] row_mask;
    logic         old_bit;
    logic         leaving;
    logic [N-1:0] toggled;

    // NOTE: every signal assigned in this block gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        fsm_d      = fsm_q;
        state_d    = state_q;
        r_d        = r_q;
        t_d        = t_q;
        p_d        = p_q;
        exit_d     = 1'b0;
        overflow_d = 1'b0;
        jam_d      = 1'b0;
        row_d      = row_q;

        // A one-hot mask avoids indexing state with a row counter that may be
        // wider than the bit range.
        row_mask = N'(1) << r_q;
        old_bit  = |(state_q & row_mask);
        toggled  = state_q ^ row_mask;
        leaving  = 1'b0;

        case (fsm_q)
            IDLE: begin
                // A flip in the same cycle as a ball lands first, so the ball
                // resolves against the inverted column.
                if (gear_flip) begin
                    state_d = ~state_q;
                end
                if (ball_in) begin
                    fsm_d = ROLL;
                    r_d   = '0;
                    t_d   = '0;
                end
            end

            ROLL: begin
                jam_d = ball_in;
                if (gear_flip) begin
                    p_d = 1'b1;
                end

                if (t_q == TRANSIT_LAST) begin
                    t_d     = '0;
                    state_d = toggled;
                    if (!old_bit) begin
                        exit_d  = 1'b1;
                        row_d   = r_q;
                        leaving = 1'b1;
                    end else if (r_q == LAST_ROW) begin
                        overflow_d = 1'b1;
                        leaving    = 1'b1;
                    end else begin
                        r_d = r_q + 1'b1;
                    end

                    // The deferred inversion lands after the row toggle. A
                    // gear pulse on this very edge merges with the pending one
                    // rather than being lost once the flag clears.
                    if (leaving) begin
                        fsm_d = IDLE;
                        p_d   = 1'b0;
                        if (p_q || gear_flip) begin
                            state_d = ~toggled;
                        end
                    end
                end else begin
                    t_d = t_q + 1'b1;
                end
            end

            default: begin
                fsm_d = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // its pre-edge inputs, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q      <= IDLE;
            state_q    <= INIT;
            r_q        <= '0;
            t_q        <= '0;
            p_q        <= 1'b0;
            exit_q     <= 1'b0;
            overflow_q <= 1'b0;
            jam_q      <= 1'b0;
            row_q      <= '0;
        end else begin
            fsm_q      <= fsm_d;
            state_q    <= state_d;
            r_q        <= r_d;
            t_q        <= t_d;
            p_q        <= p_d;
            exit_q     <= exit_d;
            overflow_q <= overflow_d;
            jam_q      <= jam_d;
            row_q      <= row_d;
        end
    end

    assign ready      = (fsm_q == IDLE);
    assign o_exit     = exit_q;
    assign o_row      = row_q;
    assign o_overflow = overflow_q;
    assign o_jam      = jam_q;
    assign state      = state_q;

endmodule

// File: tb/tb_bit_counter_column.sv
// -----------------------------------------------------------------------------
// tb_bit_counter_column
//
// Five N=4 columns with different INIT/TRANSIT settings, exercised one at a
// time. The 16-ball walk is table driven; the jam, deferred flip, combined
// ball+flip, mid-carry reset and back-to-back scenarios are hand sequences.
// -----------------------------------------------------------------------------
module tb_bit_counter_column;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       ball_in   [5];
    logic       gear_flip [5];
    logic       ready     [5];
    logic       o_exit    [5];
    logic [2:0] o_row     [5];
    logic       o_overflow[5];
    logic       o_jam     [5];
    logic [3:0] state     [5];

    always #5 clk = ~clk;

    bit_counter_column #(.N(N), .INIT(4'b0000), .TRANSIT(2)) dut_a (
        .clk(clk), .rst(rst), .ball_in(ball_in[0]), .gear_flip(gear_flip[0]),
        .ready(ready[0]), .o_exit(o_exit[0]), .o_row(o_row[0]),
        .o_overflow(o_overflow[0]), .o_jam(o_jam[0]), .state(state[0]));

    bit_counter_column #(.N(N), .INIT(4'b0111), .TRANSIT(1)) dut_b (
        .clk(clk), .rst(rst), .ball_in(ball_in[1]), .gear_flip(gear_flip[1]),
        .ready(ready[1]), .o_exit(o_exit[1]), .o_row(o_row[1]),
        .o_overflow(o_overflow[1]), .o_jam(o_jam[1]), .state(state[1]));

    bit_counter_column #(.N(N), .INIT(4'b0011), .TRANSIT(2)) dut_c (
        .clk(clk), .rst(rst), .ball_in(ball_in[2]), .gear_flip(gear_flip[2]),
        .ready(ready[2]), .o_exit(o_exit[2]), .o_row(o_row[2]),
        .o_overflow(o_overflow[2]), .o_jam(o_jam[2]), .state(state[2]));

    bit_counter_column #(.N(N), .INIT(4'b0000), .TRANSIT(1)) dut_d (
        .clk(clk), .rst(rst), .ball_in(ball_in[3]), .gear_flip(gear_flip[3]),
        .ready(ready[3]), .o_exit(o_exit[3]), .o_row(o_row[3]),
        .o_overflow(o_overflow[3]), .o_jam(o_jam[3]), .state(state[3]));

    bit_counter_column #(.N(N), .INIT(4'b1111), .TRANSIT(3)) dut_e (
        .clk(clk), .rst(rst), .ball_in(ball_in[4]), .gear_flip(gear_flip[4]),
        .ready(ready[4]), .o_exit(o_exit[4]), .o_row(o_row[4]),
        .o_overflow(o_overflow[4]), .o_jam(o_jam[4]), .state(state[4]));

    typedef struct {
        logic       ball;       // stimulus: one ball
        logic       gear;       // stimulus: gear pulse alongside (unused here)
        int         lat;        // cycles from acceptance to the pulse
        logic       ovf;        // 1 = overflow expected, 0 = exit expected
        logic [2:0] row;        // exit row
        logic [3:0] st;         // state after the ball
    } vec_t;

    vec_t vecs[16];

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Number of cells a ball carries through before resolving: the index of
    // the lowest 0-bit, capped at the last row.
    function automatic int carry_row(input logic [3:0] s);
        int k = 0;
        while (k < N - 1 && s[k]) k++;
        return k;
    endfunction

    // Drops one ball into unit u and waits for its exit/overflow pulse.
    task automatic run_ball(input int u, input string name, input int lat,
                            input logic ovf, input logic [2:0] row, input logic [3:0] st);
        int  n;
        bit  got;
        @(negedge clk);
        ball_in[u] = 1'b1;
        @(negedge clk);
        ball_in[u] = 1'b0;
        check({name, "_busy"}, 32'(ready[u]), 32'd0);
        n   = 0;
        got = 1'b0;
        while (!got && n < 64) begin
            @(negedge clk);
            n++;
            if (o_exit[u] || o_overflow[u]) got = 1'b1;
        end
        check({name, "_seen"}, 32'(got), 32'd1);
        check({name, "_lat"}, n, lat);
        check({name, "_ovf"}, 32'(o_overflow[u]), 32'(ovf));
        check({name, "_exit"}, 32'(o_exit[u]), 32'(!ovf));
        if (!ovf) check({name, "_row"}, 32'(o_row[u]), 32'(row));
        check({name, "_state"}, 32'(state[u]), 32'(st));
        check({name, "_ready"}, 32'(ready[u]), 32'd1);
        @(negedge clk);
        check({name, "_pulse1"}, 32'(o_exit[u] | o_overflow[u]), 32'd0);
    endtask

    initial begin
        logic [3:0] ms;
        int         busy;
        int         accepted;
        logic       m_ready;
        logic       exp_jam;

        for (int i = 0; i < 5; i++) begin
            ball_in[i]   = 1'b0;
            gear_flip[i] = 1'b0;
        end

        // Walk of 16 balls at TRANSIT=2; latency is 2*(exit row + 1).
        vecs[0]  = '{1'b1, 1'b0, 2, 1'b0, 3'd0, 4'd1};
        vecs[1]  = '{1'b1, 1'b0, 4, 1'b0, 3'd1, 4'd2};
        vecs[2]  = '{1'b1, 1'b0, 2, 1'b0, 3'd0, 4'd3};
        vecs[3]  = '{1'b1, 1'b0, 6, 1'b0, 3'd2, 4'd4};
        vecs[4]  = '{1'b1, 1'b0, 2, 1'b0, 3'd0, 4'd5};
        vecs[5]  = '{1'b1, 1'b0, 4, 1'b0, 3'd1, 4'd6};
        vecs[6]  = '{1'b1, 1'b0, 2, 1'b0, 3'd0, 4'd7};
        vecs[7]  = '{1'b1, 1'b0, 8, 1'b0, 3'd3, 4'd8};
        vecs[8]  = '{1'b1, 1'b0, 2, 1'b0, 3'd0, 4'd9};
        vecs[9]  = '{1'b1, 1'b0, 4, 1'b0, 3'd1, 4'd10};
        vecs[10] = '{1'b1, 1'b0, 2, 1'b0, 3'd0, 4'd11};
        vecs[11] = '{1'b1, 1'b0, 6, 1'b0, 3'd2, 4'd12};
        vecs[12] = '{1'b1, 1'b0, 2, 1'b0, 3'd0, 4'd13};
        vecs[13] = '{1'b1, 1'b0, 4, 1'b0, 3'd1, 4'd14};
        vecs[14] = '{1'b1, 1'b0, 2, 1'b0, 3'd0, 4'd15};
        vecs[15] = '{1'b1, 1'b0, 8, 1'b1, 3'd0, 4'd0};

        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state.
        check("rst_state_a", 32'(state[0]), 32'h0);
        check("rst_state_b", 32'(state[1]), 32'h7);
        check("rst_ready", 32'(ready[0]), 32'd1);
        check("rst_exit", 32'(o_exit[0]), 32'd0);
        check("rst_ovf", 32'(o_overflow[0]), 32'd0);
        check("rst_jam", 32'(o_jam[0]), 32'd0);
        check("rst_row", 32'(o_row[0]), 32'd0);

        // Sixteen-ball walk.
        for (int i = 0; i < 16; i++) begin
            run_ball(0, $sformatf("walk%0d", i + 1), vecs[i].lat, vecs[i].ovf,
                     vecs[i].row, vecs[i].st);
        end
        check("walk_row_hold", 32'(o_row[0]), 32'd0);

        // INIT=0111, TRANSIT=1: ball at E0, second ball at E0+1 is jammed.
        do_reset();
        @(negedge clk);
        ball_in[1] = 1'b1;
        @(negedge clk);                               // E0
        check("jam_busy", 32'(ready[1]), 32'd0);
        @(negedge clk);                               // E0+1
        ball_in[1] = 1'b0;
        check("jam_pulse", 32'(o_jam[1]), 32'd1);
        check("jam_no_exit", 32'(o_exit[1]), 32'd0);
        check("jam_st1", 32'(state[1]), 32'h6);
        @(negedge clk);                               // E0+2
        check("jam_clear", 32'(o_jam[1]), 32'd0);
        check("jam_st2", 32'(state[1]), 32'h4);
        @(negedge clk);                               // E0+3
        check("jam_st3", 32'(state[1]), 32'h0);
        check("jam_no_exit3", 32'(o_exit[1]), 32'd0);
        @(negedge clk);                               // E0+4
        check("jam_exit", 32'(o_exit[1]), 32'd1);
        check("jam_row", 32'(o_row[1]), 32'd3);
        check("jam_state", 32'(state[1]), 32'h8);
        check("jam_ready", 32'(ready[1]), 32'd1);

        // INIT=0011, TRANSIT=2: two gear pulses during the roll merge into one.
        do_reset();
        @(negedge clk);
        ball_in[2] = 1'b1;
        @(negedge clk);                               // E0
        ball_in[2]   = 1'b0;
        gear_flip[2] = 1'b1;
        @(negedge clk);                               // E0+1
        gear_flip[2] = 1'b0;
        @(negedge clk);                               // E0+2
        check("pend_st2", 32'(state[2]), 32'h2);
        gear_flip[2] = 1'b1;
        @(negedge clk);                               // E0+3
        gear_flip[2] = 1'b0;
        @(negedge clk);                               // E0+4
        check("pend_st4", 32'(state[2]), 32'h0);
        check("pend_no_exit4", 32'(o_exit[2]), 32'd0);
        @(negedge clk);                               // E0+5
        check("pend_no_exit5", 32'(o_exit[2]), 32'd0);
        @(negedge clk);                               // E0+6
        check("pend_exit", 32'(o_exit[2]), 32'd1);
        check("pend_row", 32'(o_row[2]), 32'd2);
        check("pend_state", 32'(state[2]), 32'hB);
        @(negedge clk);                               // E0+7
        check("pend_once", 32'(state[2]), 32'hB);
        check("pend_ready", 32'(ready[2]), 32'd1);

        // TRANSIT=1: get to 0001, then ball and gear in the same idle cycle.
        do_reset();
        run_ball(3, "pre", 1, 1'b0, 3'd0, 4'h1);
        ball_in[3]   = 1'b1;
        gear_flip[3] = 1'b1;
        @(negedge clk);
        ball_in[3]   = 1'b0;
        gear_flip[3] = 1'b0;
        check("both_flip", 32'(state[3]), 32'hE);
        check("both_busy", 32'(ready[3]), 32'd0);
        @(negedge clk);
        check("both_exit", 32'(o_exit[3]), 32'd1);
        check("both_row", 32'(o_row[3]), 32'd0);
        check("both_state", 32'(state[3]), 32'hF);
        gear_flip[3] = 1'b1;
        @(negedge clk);
        gear_flip[3] = 1'b0;
        check("idle_flip", 32'(state[3]), 32'h0);

        // Back-to-back balls with ball_in held high, against a spec model.
        do_reset();
        ms       = 4'h0;
        busy     = 0;
        accepted = 0;
        ball_in[3] = 1'b1;
        for (int c = 0; c < 60; c++) begin
            m_ready = (busy == 0);
            check("b2b_ready", 32'(ready[3]), 32'(m_ready));
            if (m_ready) begin
                accepted++;
                busy    = carry_row(ms) + 1;
                exp_jam = 1'b0;
            end else begin
                exp_jam = 1'b1;
                busy--;
                if (busy == 0) ms = ms + 4'd1;
            end
            @(negedge clk);
            check("b2b_jam", 32'(o_jam[3]), 32'(exp_jam));
            if (busy == 0) check("b2b_state", 32'(state[3]), 32'(ms));
        end
        ball_in[3] = 1'b0;
        repeat (8) @(negedge clk);
        while (busy > 0) begin
            busy--;
            if (busy == 0) ms = ms + 4'd1;
        end
        check("b2b_final", 32'(state[3]), 32'(ms));
        check("b2b_count", 32'(ms), 32'(accepted % 16));

        // INIT=1111, TRANSIT=3: reset mid-carry discards the ball.
        do_reset();
        @(negedge clk);
        ball_in[4] = 1'b1;
        @(negedge clk);                               // E0
        ball_in[4] = 1'b0;
        for (int j = 1; j <= 4; j++) begin
            @(negedge clk);                           // E0+j
            check("rr_quiet", 32'(o_exit[4] | o_overflow[4]), 32'd0);
            if (j == 3) check("rr_partial", 32'(state[4]), 32'hE);
        end
        rst = 1'b1;
        @(negedge clk);                               // E0+5
        rst = 1'b0;
        check("rr_state", 32'(state[4]), 32'hF);
        check("rr_ready", 32'(ready[4]), 32'd1);
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            check("rr_no_pulse", 32'(o_exit[4] | o_overflow[4]), 32'd0);
        end
        check("rr_hold", 32'(state[4]), 32'hF);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
